// File: rtl/fp16_accum_seq.sv
// rtl/fp16_accum_seq.sv - sequential half-precision stream accumulator around an external combinational adder
module fp16_accum_seq #(
    parameter int FLOAT_WIDTH = 16,
    parameter int CNT_W       = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FLOAT_WIDTH-1:0] in_data,
    input  logic                   in_sub,
    input  logic                   in_last,
    output logic [FLOAT_WIDTH-1:0] add_float1,
    output logic [FLOAT_WIDTH-1:0] add_float2,
    output logic                   add_subtract,
    input  logic [FLOAT_WIDTH-1:0] add_sum,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FLOAT_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_nan
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [FLOAT_WIDTH-1:0] acc;
    logic [CNT_W-1:0]       count;
    logic                   nan_sticky;

    logic                   accept;
    logic                   sum_is_nan;
    logic [CNT_W-1:0]       count_inc;
    logic                   nan_upd;

    assign add_float1   = acc;
    assign add_float2   = in_data;
    assign add_subtract = in_sub;

    assign accept     = in_valid && in_ready;
    assign sum_is_nan = (add_sum[14:10] == 5'h1F) && (add_sum[9:0] != 10'd0);
    assign count_inc  = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
    assign nan_upd    = nan_sticky | sum_is_nan;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_next = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // in_ready depends on state alone so upstream never sees a combinational path from in_valid
    always_comb begin
        in_ready  = (state != HOLD);
        out_valid = (state == HOLD);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc        <= '0;
            count      <= '0;
            nan_sticky <= 1'b0;
            out_data   <= '0;
            out_count  <= '0;
            out_nan    <= 1'b0;
        end else if (state == HOLD) begin
            if (out_ready) begin
                acc        <= '0;
                count      <= '0;
                nan_sticky <= 1'b0;
            end
        end else if (accept) begin
            acc        <= add_sum;
            count      <= count_inc;
            nan_sticky <= nan_upd;
            if (in_last) begin
                out_data  <= add_sum;
                out_count <= count_inc;
                out_nan   <= nan_upd;
            end
        end
    end

endmodule

// File: tb/tb_fp16_accum_seq.sv
// tb/tb_fp16_accum_seq.sv - directed self-checking bench for fp16_accum_seq
module tb_fp16_accum_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_sub;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a,  in_ready_b;
    logic [15:0] f1_a, f2_a, f1_b, f2_b;
    logic        sub_a, sub_b;
    logic [15:0] sum_a, sum_b;
    logic        out_valid_a, out_valid_b;
    logic [15:0] out_data_a,  out_data_b;
    logic [7:0]  out_count_a;
    logic [1:0]  out_count_b;
    logic        out_nan_a,   out_nan_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    // Adder stand-in: exact results for the operand pairs the vectors produce
    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b, input logic s);
        case ({s, a, b})
            {1'b0, 16'h0000, 16'h3C00}: fadd = 16'h3C00;
            {1'b0, 16'h3C00, 16'h4000}: fadd = 16'h4200;
            {1'b0, 16'h4200, 16'h3800}: fadd = 16'h4300;
            {1'b0, 16'h0000, 16'h4200}: fadd = 16'h4200;
            {1'b1, 16'h4200, 16'h3C00}: fadd = 16'h4000;
            {1'b0, 16'h0000, 16'hBC00}: fadd = 16'hBC00;
            {1'b0, 16'h3C00, 16'h7E00}: fadd = 16'h7E00;
            {1'b0, 16'h7E00, 16'h3C00}: fadd = 16'h7E00;
            {1'b0, 16'h3C00, 16'h3C00}: fadd = 16'h4000;
            {1'b0, 16'h4000, 16'h3C00}: fadd = 16'h4200;
            {1'b0, 16'h4200, 16'h3C00}: fadd = 16'h4400;
            {1'b0, 16'h4400, 16'h3C00}: fadd = 16'h4500;
            {1'b0, 16'h0000, 16'h4000}: fadd = 16'h4000;
            {1'b0, 16'h4000, 16'h4000}: fadd = 16'h4400;
            default:                    fadd = 16'h0000;
        endcase
    endfunction

    assign sum_a = fadd(f1_a, f2_a, sub_a);
    assign sum_b = fadd(f1_b, f2_b, sub_b);

    fp16_accum_seq #(.FLOAT_WIDTH(16), .CNT_W(8)) u_dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .in_sub(in_sub), .in_last(in_last),
        .add_float1(f1_a), .add_float2(f2_a), .add_subtract(sub_a), .add_sum(sum_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .out_count(out_count_a), .out_nan(out_nan_a)
    );

    fp16_accum_seq #(.FLOAT_WIDTH(16), .CNT_W(2)) u_dut_sat (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .in_sub(in_sub), .in_last(in_last),
        .add_float1(f1_b), .add_float2(f2_b), .add_subtract(sub_b), .add_sum(sum_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .out_count(out_count_b), .out_nan(out_nan_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic s, input logic l);
        in_valid = v;
        in_data  = d;
        in_sub   = s;
        in_last  = l;
    endtask

    initial begin
        RST = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        step();
        step();
        check("rst_out_valid", out_valid_a, 0);
        check("rst_in_ready",  in_ready_a,  1);
        check("rst_out_data",  out_data_a,  0);
        check("rst_out_count", out_count_a, 0);
        check("rst_out_nan",   out_nan_a,   0);
        check("rst_acc",       f1_a,        0);
        RST = 1'b0;
        step();
        check("idle_hold_acc", f1_a, 0);

        // 1 + 2 + 0.5 = 3.5
        drive(1'b1, 16'h3C00, 1'b0, 1'b0);
        check("pass_float2", f2_a, 16'h3C00);
        step();
        check("t1_acc1", f1_a, 16'h3C00);
        check("t1_busy_valid", out_valid_a, 0);
        drive(1'b1, 16'h4000, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h3800, 1'b0, 1'b1);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        check("t1_valid", out_valid_a, 1);
        check("t1_data",  out_data_a,  16'h4300);
        check("t1_count", out_count_a, 3);
        check("t1_nan",   out_nan_a,   0);
        check("t1_ready_hold", in_ready_a, 0);
        step();
        check("t1_valid_drop", out_valid_a, 0);
        check("t1_ready_back", in_ready_a,  1);
        check("t1_acc_clear",  f1_a,        0);

        // 3 - 1 = 2
        drive(1'b1, 16'h4200, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h3C00, 1'b1, 1'b1);
        check("pass_subtract", sub_a, 1);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        check("t2_valid", out_valid_a, 1);
        check("t2_data",  out_data_a,  16'h4000);
        check("t2_count", out_count_a, 2);
        step();

        // single element with back-pressure; in_valid during HOLD must be ignored
        out_ready = 1'b0;
        drive(1'b1, 16'hBC00, 1'b0, 1'b1);
        step();
        drive(1'b1, 16'h4000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("t3_valid",    out_valid_a, 1);
            check("t3_data",     out_data_a,  16'hBC00);
            check("t3_count",    out_count_a, 1);
            check("t3_in_ready", in_ready_a,  0);
            check("t3_acc",      f1_a,        16'hBC00);
            step();
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        out_ready = 1'b1;
        check("t3_still_valid", out_valid_a, 1);
        step();
        check("t3_idle_valid", out_valid_a, 0);
        check("t3_idle_ready", in_ready_a,  1);
        check("t3_acc_clear",  f1_a,        0);

        // NaN in the middle of a stream is sticky
        drive(1'b1, 16'h3C00, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h7E00, 1'b0, 1'b0);
        step();
        drive(1'b1, 16'h3C00, 1'b0, 1'b1);
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        check("t4_valid",    out_valid_a, 1);
        check("t4_nan",      out_nan_a,   1);
        check("t4_data_exp", out_data_a[14:10], 5'h1F);
        check("t4_data_frac_nz", (out_data_a[9:0] != 10'd0), 1);
        check("t4_count",    out_count_a, 3);
        step();

        // five ones: 2-bit counter saturates at 3, 8-bit counter reads 5
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h3C00, 1'b0, (i == 4));
            step();
        end
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        check("t5_valid",     out_valid_b, 1);
        check("t5_data",      out_data_b,  16'h4500);
        check("t5_count_sat", out_count_b, 3);
        check("t5_count_wide", out_count_a, 5);
        check("t5_nan",       out_nan_b,   0);
        step();
        check("t5_nan_cleared", out_nan_a, 0);

        // reset mid-stream wins over a simultaneous accept
        drive(1'b1, 16'h4000, 1'b0, 1'b0);
        step();
        step();
        check("t6_accum_valid", out_valid_a, 0);
        check("t6_acc_pre",     f1_a,        16'h4400);
        RST = 1'b1;
        drive(1'b1, 16'h3C00, 1'b0, 1'b1);
        step();
        check("t6_rst_valid", out_valid_a, 0);
        check("t6_rst_ready", in_ready_a,  1);
        check("t6_rst_acc",   f1_a,        0);
        RST = 1'b0;
        step();
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        check("t6_valid", out_valid_a, 1);
        check("t6_data",  out_data_a,  16'h3C00);
        check("t6_count", out_count_a, 1);
        check("t6_nan",   out_nan_a,   0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp16_accum_seq.md
Name: fp16_accum_seq

Overview:
- Sequential accumulation controller for half-precision streams. It sits directly around the team's combinational half-precision adder (float_add).
- Drives the adder's float1, float2 and subtract operands, and captures the adder's sum into a running accumulator register.
- Accepts operands over a valid/ready stream and emits one accumulated result per stream, delimited by a last flag.

Parameters:
FLOAT_WIDTH, 16 (HALF_FLOAT_W), operand/result width; only 16 supported.
CNT_W, 8, width of accepted-element counter.

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  synchronous active-high reset
in_valid  input  1  upstream operand valid
in_ready  output  1  block can accept operand this cycle
in_data  input  FLOAT_WIDTH  half-precision operand
in_sub  input  1  1 = subtract in_data from accumulator, 0 = add
in_last  input  1  operand is final element of current stream
add_float1  output  FLOAT_WIDTH  to adder float1; always = acc register
add_float2  output  FLOAT_WIDTH  to adder float2; always = in_data
add_subtract  output  1  to adder subtract; always = in_sub
add_sum  input  FLOAT_WIDTH  combinational sum returned from adder
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  FLOAT_WIDTH  accumulated result
out_count  output  CNT_W  elements accepted in this stream, saturating
out_nan  output  1  sticky: some intermediate sum was NaN

Behaviour:
- One clock CLK; reset RST is synchronous, active-high; all registers update only on CLK rising edge.
- States: IDLE (no element yet), ACCUM (stream in progress), HOLD (result presented).
- Reset values: state=IDLE, acc=0x0000, count=0, nan_sticky=0, out_valid=0, out_data=0x0000, out_count=0, out_nan=0.
- in_ready=1 in IDLE and ACCUM, 0 in HOLD; in_ready is a function of state only, never of in_valid.
- Accept = in_valid & in_ready.
- On accept:
  - acc <= add_sum.
  - count <= count+1, saturating at all-ones.
  - nan_sticky |= (add_sum[14:10]==5'h1F & add_sum[9:0]!=0).
- Accept with in_last=0: IDLE->ACCUM, or remain in ACCUM.
- Accept with in_last=1: ->HOLD from IDLE or ACCUM. Single-element streams are legal.
  - Next cycle: out_valid=1, out_data=add_sum captured, out_count=count incl. this element, out_nan=updated sticky.
- Latency: result valid the cycle after the last element is accepted. Throughput: one element per cycle while not in HOLD.
- HOLD: out_data, out_count and out_nan stay stable while out_valid=1 & out_ready=0.
- HOLD with out_ready=1:
  - out_valid<=0; acc<=0x0000, count<=0, nan_sticky<=0; ->IDLE. in_ready returns next cycle.
  - out_data, out_count and out_nan hold their last values (don't-care while out_valid=0).
- No new stream overlaps HOLD. in_valid during HOLD is ignored and must be held by upstream.
- Arithmetic (rounding, infinity, NaN propagation) is entirely the adder's. The block never alters add_sum.
  - Infinity results are accumulated as-is.
- No accept (in_valid=0) in IDLE/ACCUM: all state holds.
- RST mid-stream or in HOLD: discards acc/count/sticky, drops out_valid, returns to IDLE the next cycle; RST has priority over accept.

Test Plan:
- Stream 0x3C00, 0x4000, 0x3800(last), in_sub=0, out_ready=1 -> one cycle after last accept: out_valid=1, out_data=0x4300 (3.5), out_count=3, out_nan=0; in_ready=0 in that cycle, 1 the next.
- Stream 0x4200 (add), then 0x3C00 (in_sub=1, last) -> out_data=0x4000, out_count=2.
- Single element 0xBC00 last, out_ready held 0 for 3 cycles -> out_valid=1, out_data=0xBC00 stable all 3 cycles, in_ready=0, in_valid ignored; out_ready=1 -> IDLE next cycle, acc=0.
- Stream 0x3C00, 0x7E00, 0x3C00(last) -> out_nan=1, out_data is NaN (exp=0x1F, frac!=0), out_count=3.
- CNT_W=2: five elements of 0x3C00, last on fifth -> out_data=0x4500 (5.0), out_count=3 (saturated).
- Two elements accepted (0x4000, 0x4000), RST=1 one cycle, then 0x3C00 last -> out_data=0x3C00, out_count=1, out_nan=0; out_valid=0 during and after the reset cycle until the new result.
